// File: rtl/pwr_seq_pkg.sv
// Shared types for the power-domain sequencer: state encoding, the
// registered output bundle and the state-to-output decode.
package pwr_seq_pkg;

    typedef enum logic [3:0] {
        OFF     = 4'd0,
        SW_ON   = 4'd1,
        RESTORE = 4'd2,
        LS_ON   = 4'd3,
        DEISO   = 4'd4,
        ON      = 4'd5,
        ISO     = 4'd6,
        SAVE    = 4'd7,
        LS_OFF  = 4'd8,
        SW_OFF  = 4'd9,
        FAULT   = 4'd10
    } pwr_seq_state_e;

    localparam pwr_seq_state_e RESET_STATE = OFF;

    typedef struct packed {
        logic sw_en;
        logic iso_en;
        logic ls_en;
        logic save;
        logic restore;
        logic domain_on;
        logic busy;
        logic err;
    } pwr_seq_out_t;

    // Moore decode; isolation defaults on so any unlisted state stays clamped.
    function automatic pwr_seq_out_t state_outputs(input pwr_seq_state_e s);
        pwr_seq_out_t o;
        o        = '0;
        o.iso_en = 1'b1;
        case (s)
            OFF: ;
            SW_ON: begin
                o.sw_en = 1'b1;
                o.busy  = 1'b1;
            end
            RESTORE: begin
                o.sw_en   = 1'b1;
                o.restore = 1'b1;
                o.busy    = 1'b1;
            end
            LS_ON: begin
                o.sw_en = 1'b1;
                o.ls_en = 1'b1;
                o.busy  = 1'b1;
            end
            DEISO: begin
                o.sw_en  = 1'b1;
                o.ls_en  = 1'b1;
                o.iso_en = 1'b0;
                o.busy   = 1'b1;
            end
            ON: begin
                o.sw_en     = 1'b1;
                o.ls_en     = 1'b1;
                o.iso_en    = 1'b0;
                o.domain_on = 1'b1;
            end
            ISO: begin
                o.sw_en = 1'b1;
                o.ls_en = 1'b1;
                o.busy  = 1'b1;
            end
            SAVE: begin
                o.sw_en = 1'b1;
                o.ls_en = 1'b1;
                o.save  = 1'b1;
                o.busy  = 1'b1;
            end
            LS_OFF: begin
                o.sw_en = 1'b1;
                o.busy  = 1'b1;
            end
            SW_OFF: begin
                o.busy = 1'b1;
            end
            FAULT: begin
                o.err = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Shared down-counter for settle dwell and switch-ack timeout.
// Load has priority over decrement; the count holds at zero.
module pwr_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, or step down towards zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwr_domain_sequencer.sv
// Power-domain sequencer: orders isolation, level shifter, retention and
// power switch so no crossing is ever unclamped or unshifted.
// Optional macro PWR_SEQ_RETENTION_EN adds the SAVE/RESTORE pulse states;
// without it save/restore are tied low and each sequence is one cycle shorter.
//
// state   | meaning
// --------+----------------------------------------------------------
// OFF     | domain unpowered, clamped; waits for pwr_up_req
// SW_ON   | switch enabled; waits for sw_ack=1 (timeout -> FAULT)
// RESTORE | one-cycle retention restore pulse
// LS_ON   | level shifter enabled; settle dwell
// DEISO   | clamps released for one cycle
// ON      | domain up; waits for pwr_down_req
// ISO     | clamps asserted; settle dwell
// SAVE    | one-cycle retention save pulse
// LS_OFF  | level shifter disabled for one cycle
// SW_OFF  | switch disabled; waits for sw_ack=0 (timeout -> FAULT)
// FAULT   | switch ack timeout; safe outputs until err_clr
module pwr_domain_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SW_TIMEOUT    = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwr_up_req,
    input  logic pwr_down_req,
    input  logic err_clr,
    input  logic sw_ack,
    output logic sw_en,
    output logic iso_en,
    output logic ls_en,
    output logic save,
    output logic restore,
    output logic domain_on,
    output logic busy,
    output logic err
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SW_TIMEOUT) ? SETTLE_CYCLES : SW_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(SW_TIMEOUT - 1);

    pwr_seq_state_e   state_q;
    pwr_seq_state_e   state_d;
    pwr_seq_out_t     out_q;
    pwr_seq_out_t     out_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    pwr_seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next state plus timer control; the timer reloads on entry to a timed state.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        case (state_q)
            OFF: begin
                if (pwr_up_req) state_d = SW_ON;
            end
            SW_ON: begin
                if (sw_ack) begin
`ifdef PWR_SEQ_RETENTION_EN
                    state_d = RESTORE;
`else
                    state_d = LS_ON;
`endif
                end else if (tmr_zero) begin
                    state_d = FAULT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            RESTORE: state_d = LS_ON;
            LS_ON: begin
                if (tmr_zero) state_d = DEISO;
                else          tmr_dec = 1'b1;
            end
            DEISO: state_d = ON;
            ON: begin
                if (pwr_down_req) state_d = ISO;
            end
            ISO: begin
                if (tmr_zero) begin
`ifdef PWR_SEQ_RETENTION_EN
                    state_d = SAVE;
`else
                    state_d = LS_OFF;
`endif
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SAVE:   state_d = LS_OFF;
            LS_OFF: state_d = SW_OFF;
            SW_OFF: begin
                if (!sw_ack) begin
                    state_d = OFF;
                end else if (tmr_zero) begin
                    state_d = FAULT;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            FAULT: begin
                if (err_clr) state_d = OFF;
            end
            default: state_d = RESET_STATE;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                ISO, LS_ON: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LOAD;
                end
                SW_ON, SW_OFF: begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMEOUT_LOAD;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on state entry.
    always_comb begin
        out_d = state_outputs(state_d);
`ifndef PWR_SEQ_RETENTION_EN
        out_d.save    = 1'b0;
        out_d.restore = 1'b0;
`endif
    end

    // State and output registers; reset lands clamped with the switch off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            out_q   <= state_outputs(RESET_STATE);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign sw_en     = out_q.sw_en;
    assign iso_en    = out_q.iso_en;
    assign ls_en     = out_q.ls_en;
    assign save      = out_q.save;
    assign restore   = out_q.restore;
    assign domain_on = out_q.domain_on;
    assign busy      = out_q.busy;
    assign err       = out_q.err;

    a_iso_covers_crossing : assert property (@(posedge clk) disable iff (!rst_n)
        (!out_q.sw_en || !out_q.ls_en) |-> out_q.iso_en);
    a_ls_needs_switch : assert property (@(posedge clk) disable iff (!rst_n)
        out_q.ls_en |-> out_q.sw_en);

endmodule

// File: tb/tb_pwr_domain_sequencer.sv
// Bench for pwr_domain_sequencer. Builds with or without PWR_SEQ_RETENTION_EN.
module tb_pwr_domain_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    // {sw_en, iso_en, ls_en, save, restore, domain_on, busy, err}
    localparam logic [7:0] V_OFF     = 8'b0100_0000;
    localparam logic [7:0] V_SW_ON   = 8'b1100_0010;
    localparam logic [7:0] V_RESTORE = 8'b1100_1010;
    localparam logic [7:0] V_LS_ON   = 8'b1110_0010;
    localparam logic [7:0] V_DEISO   = 8'b1010_0010;
    localparam logic [7:0] V_ON      = 8'b1010_0100;
    localparam logic [7:0] V_ISO     = 8'b1110_0010;
    localparam logic [7:0] V_SAVE    = 8'b1111_0010;
    localparam logic [7:0] V_LS_OFF  = 8'b1100_0010;
    localparam logic [7:0] V_SW_OFF  = 8'b0100_0010;
    localparam logic [7:0] V_FAULT   = 8'b0100_0001;

`ifdef PWR_SEQ_RETENTION_EN
    localparam int UP_BASE = 7;
    localparam int DN_BASE = 7;
`else
    localparam int UP_BASE = 6;
    localparam int DN_BASE = 6;
`endif

    logic clk;
    logic rst_n;
    logic pwr_up_req;
    logic pwr_down_req;
    logic err_clr;
    logic sw_ack;
    logic sw_en;
    logic iso_en;
    logic ls_en;
    logic save;
    logic restore;
    logic domain_on;
    logic busy;
    logic err;

    pwr_domain_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .SW_TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwr_up_req   (pwr_up_req),
        .pwr_down_req (pwr_down_req),
        .err_clr      (err_clr),
        .sw_ack       (sw_ack),
        .sw_en        (sw_en),
        .iso_en       (iso_en),
        .ls_en        (ls_en),
        .save         (save),
        .restore      (restore),
        .domain_on    (domain_on),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] vec;
    assign vec = {sw_en, iso_en, ls_en, save, restore, domain_on, busy, err};

    typedef struct {
        logic [7:0] v;
        int         gap;
        string      name;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         total = 0;
    int         bad   = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev;
    int         gap;

    task automatic push(input logic [7:0] v, input int g, input string name);
        exp_t x;
        x.v    = v;
        x.gap  = g;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Output-change monitor: every change of the output vector consumes one
    // expected entry; gap is how many cycles the previous vector was held.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev = vec;
            gap  = 0;
        end else if (vec !== prev) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got vec=%b prev=%b", vec, prev);
            end else begin
                e = q.pop_front();
                if (vec !== e.v || (e.gap != 0 && gap != e.gap)) begin
                    bad++;
                    $display("FAIL %s: got vec=%b held=%0d want vec=%b held=%0d",
                             e.name, vec, gap, e.v, e.gap);
                end
            end
            prev = vec;
            gap  = 1;
        end else begin
            gap++;
        end
        if (rst_n === 1'b1) begin
            total += 2;
            if ((!sw_en || !ls_en) && !iso_en) begin
                bad++;
                $display("FAIL inv_iso: got iso_en=%b with sw_en=%b ls_en=%b want iso_en=1", iso_en, sw_en, ls_en);
            end
            if (ls_en && !sw_en) begin
                bad++;
                $display("FAIL inv_ls: got ls_en=1 sw_en=0 want sw_en=1");
            end
        end
    end

    task automatic drained(input string name);
        #2;
        check(name, q.size(), 0);
    endtask

    // Power-up from OFF; ack follows sw_en after d cycles.
    task automatic do_power_up(input bit both, input bit pulse_down, input int d);
        int j;
        int cyc;
        bit done;
        j = -1; cyc = 0; done = 1'b0;
        push(V_SW_ON, 0, "up_sw_on");
`ifdef PWR_SEQ_RETENTION_EN
        push(V_RESTORE, d, "up_restore");
        push(V_LS_ON, 1, "up_ls_on");
`else
        push(V_LS_ON, d, "up_ls_on");
`endif
        push(V_DEISO, SETTLE, "up_deiso");
        push(V_ON, 1, "up_on");
        pwr_up_req = 1'b1;
        if (both) pwr_down_req = 1'b1;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                pwr_up_req   = 1'b0;
                pwr_down_req = 1'b0;
            end
            if (j < 0 && sw_en) j = k;
            if (j >= 0 && k == j + d - 1) sw_ack = 1'b1;
            if (pulse_down && j >= 0 && k == j + d + 1) pwr_down_req = 1'b1;
            if (pulse_down && j >= 0 && k == j + d + 2) pwr_down_req = 1'b0;
            if (domain_on) begin
                done = 1'b1;
                cyc  = k;
            end
        end
        check("up_reached_on", done, 1);
        check("up_latency", cyc, UP_BASE + d);
    endtask

    // Power-down from ON; ack drops d cycles after sw_en falls.
    task automatic do_power_down(input int d);
        int j;
        int cyc;
        bit done;
        bit iso_drop;
        bit busy_drop;
        j = -1; cyc = 0; done = 1'b0; iso_drop = 1'b0; busy_drop = 1'b0;
        push(V_ISO, 0, "dn_iso");
`ifdef PWR_SEQ_RETENTION_EN
        push(V_SAVE, SETTLE, "dn_save");
        push(V_LS_OFF, 1, "dn_ls_off");
`else
        push(V_LS_OFF, SETTLE, "dn_ls_off");
`endif
        push(V_SW_OFF, 1, "dn_sw_off");
        push(V_OFF, d, "dn_off");
        pwr_down_req = 1'b1;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (k == 1) pwr_down_req = 1'b0;
            if (!iso_en) iso_drop = 1'b1;
            if (j < 0 && !sw_en) j = k;
            if (j >= 0 && k == j + d - 1) sw_ack = 1'b0;
            if (!busy && !domain_on) begin
                done = 1'b1;
                cyc  = k;
            end else if (!busy) begin
                busy_drop = 1'b1;
            end
        end
        check("dn_reached_off", done, 1);
        check("dn_latency", cyc, DN_BASE + d);
        check("dn_iso_held", iso_drop, 0);
        check("dn_busy_held", busy_drop, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kf;
        bit seen;
        int j;
        rst_n        = 1'b0;
        pwr_up_req   = 1'b0;
        pwr_down_req = 1'b0;
        err_clr      = 1'b0;
        sw_ack       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", vec, V_OFF);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_off", vec, V_OFF);
        mon_en = 1'b1;

        // Scenario 1: power-up, ack 3 cycles after sw_en.
        do_power_up(1'b0, 1'b0, 3);
        drained("s1_drained");

        // Ack glitch and up request while ON are ignored.
        @(negedge clk); sw_ack = 1'b0;
        @(negedge clk); sw_ack = 1'b1;
        pwr_up_req = 1'b1;
        repeat (3) @(negedge clk);
        pwr_up_req = 1'b0;
        @(negedge clk);
        check("on_ignores_glitch_up", vec, V_ON);

        // Scenario 2: power-down, ack falls 2 cycles after sw_en.
        do_power_down(2);
        drained("s2_drained");

        // Ack glitch and down request while OFF are ignored.
        @(negedge clk); sw_ack = 1'b1;
        @(negedge clk); sw_ack = 1'b0;
        pwr_down_req = 1'b1;
        repeat (3) @(negedge clk);
        pwr_down_req = 1'b0;
        @(negedge clk);
        check("off_ignores_glitch_down", vec, V_OFF);

        // Scenario 3: ack never arrives -> FAULT, request ignored, err_clr -> OFF.
        push(V_SW_ON, 0, "to_sw_on");
        push(V_FAULT, TIMEOUT, "to_fault");
        push(V_OFF, 3, "to_clear");
        pwr_up_req = 1'b1;
        kf = 0;
        for (int k = 1; k <= 100 && kf == 0; k++) begin
            @(negedge clk);
            if (k == 1) pwr_up_req = 1'b0;
            if (err) kf = k;
        end
        check("fault_latency", kf, 1 + TIMEOUT);
        check("fault_outputs", vec, V_FAULT);
        pwr_up_req = 1'b1;
        repeat (2) @(negedge clk);
        check("fault_holds_with_req", vec, V_FAULT);
        pwr_up_req = 1'b0;
        err_clr    = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("fault_cleared_err", err, 0);
        check("fault_cleared_off", vec, V_OFF);
        drained("s3_drained");

        // Scenario 4: reset asserted in LS_ON.
        push(V_SW_ON, 0, "rs_sw_on");
`ifdef PWR_SEQ_RETENTION_EN
        push(V_RESTORE, 2, "rs_restore");
        push(V_LS_ON, 1, "rs_ls_on");
`else
        push(V_LS_ON, 2, "rs_ls_on");
`endif
        pwr_up_req = 1'b1;
        j = -1;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) pwr_up_req = 1'b0;
            if (j < 0 && sw_en) j = k;
            if (j >= 0 && k == j + 1) sw_ack = 1'b1;
            if (ls_en) seen = 1'b1;
        end
        check("rs_reached_ls_on", seen, 1);
        #2;
        mon_en = 1'b0;
        check("rs_pre_drained", q.size(), 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rs_async_outputs", vec, V_OFF);
        sw_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rs_held_outputs", vec, V_OFF);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rs_after_release", vec, V_OFF);

        // Scenario 5: both requests in OFF, down pulse mid power-up.
        do_power_up(1'b1, 1'b1, 3);
        repeat (3) @(negedge clk);
        check("s5_stays_on", vec, V_ON);
        drained("s5_drained");
        do_power_down(1);
        drained("s5_down_drained");

        repeat (5) @(negedge clk);
        check("final_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
